// File: rtl/inv_fleet_ctrl_pkg.sv
// Shared definitions for the invader fleet controller: state encodings,
// screen constants and default ship geometry.
package inv_fleet_ctrl_pkg;

   localparam logic [2:0] ST_MOVE_R = 3'd0;
   localparam logic [2:0] ST_MOVE_L = 3'd1;
   localparam logic [2:0] ST_DOWN_R = 3'd2;
   localparam logic [2:0] ST_DOWN_L = 3'd3;
   localparam logic [2:0] ST_HALT   = 3'd4;

   localparam int SCREEN_W      = 800;
   localparam int LINE_Y        = 544;
   localparam int DEF_SHIP_W    = 60;
   localparam int DEF_COL_PITCH = 80;

   // Index width that stays legal for single-entry ranges.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/inv_edge_finder.sv
// Combinational priority encoder: lowest and highest live column of the fleet.
module inv_edge_finder
   import inv_fleet_ctrl_pkg::*;
#(
   parameter int COLS = 8,
   parameter int CW   = idx_w(COLS)
) (
   input  logic [COLS-1:0] alive_cols,
   output logic [CW-1:0]   lcol,
   output logic [CW-1:0]   rcol,
   output logic            any
);

   always_comb begin
      lcol = '0;
      rcol = '0;
      for (int i = COLS - 1; i >= 0; i--)
         if (alive_cols[i]) lcol = CW'(i);
      for (int i = 0; i < COLS; i++)
         if (alive_cols[i]) rcol = CW'(i);
   end

   assign any = |alive_cols;

endmodule

// File: rtl/inv_fleet_ctrl.sv
// Fleet movement master: paced shift pulses, edge reversal with a descent,
// offset tracking and sticky game_over / fleet_cleared flags.
module inv_fleet_ctrl
   import inv_fleet_ctrl_pkg::*;
#(
   parameter int COLS        = 8,
   parameter int COL_PITCH   = DEF_COL_PITCH,
   parameter int SHIP_W      = DEF_SHIP_W,
   parameter int FLEET_X0    = 40,
   parameter int LEFT_LIMIT  = 10,
   parameter int RIGHT_LIMIT = SCREEN_W - 10,
   parameter int DOWN_PX     = 15,
   parameter int STEP_DIV    = 400000
) (
   input  logic               clk,
   input  logic               on_sw,
   input  logic               en,
   input  logic [COLS-1:0]    alive_cols,
   input  logic               line_crossed_any,
   output logic               shift_right,
   output logic               shift_left,
   output logic               shift_down,
   output logic               dir_right,
   output logic signed [11:0] fleet_dx,
   output logic [10:0]        fleet_dy,
   output logic               game_over,
   output logic               fleet_cleared
);

   localparam int CW = idx_w(COLS);
   localparam int DW = idx_w(STEP_DIV);
   localparam int NW = idx_w(DOWN_PX + 1);

   localparam logic signed [11:0] LLIM = 12'(LEFT_LIMIT);
   localparam logic signed [11:0] RLIM = 12'(RIGHT_LIMIT);

   logic [CW-1:0]      lcol, rcol;
   logic               any_alive;
   logic [DW-1:0]      div_cnt;
   logic [NW-1:0]      down_cnt, down_nxt;
   logic [2:0]         state;
   logic signed [11:0] left_edge, right_edge;
   logic               run, tick;

   inv_edge_finder #(.COLS(COLS)) u_edge (
      .alive_cols (alive_cols),
      .lcol       (lcol),
      .rcol       (rcol),
      .any        (any_alive)
   );

   assign left_edge  = 12'(FLEET_X0) + fleet_dx + 12'(int'(lcol) * COL_PITCH);
   assign right_edge = 12'(FLEET_X0) + fleet_dx + 12'(int'(rcol) * COL_PITCH) + 12'(SHIP_W);

   assign run      = en && (state != ST_HALT);
   assign tick     = run && (div_cnt == DW'(STEP_DIV - 1));
   assign down_nxt = down_cnt + NW'(1);

   always_ff @(posedge clk) begin
      if (!on_sw) begin
         shift_right   <= 1'b0;
         shift_left    <= 1'b0;
         shift_down    <= 1'b0;
         dir_right     <= 1'b1;
         fleet_dx      <= '0;
         fleet_dy      <= '0;
         game_over     <= 1'b0;
         fleet_cleared <= 1'b0;
         div_cnt       <= '0;
         down_cnt      <= '0;
         state         <= ST_MOVE_R;
      end else begin
         shift_right <= 1'b0;
         shift_left  <= 1'b0;
         shift_down  <= 1'b0;

         // Offsets follow the pulses on the same edge the ships move.
         if (shift_right)
            fleet_dx <= fleet_dx + 12'sd1;
         else if (shift_left)
            fleet_dx <= fleet_dx - 12'sd1;
         if (shift_down && fleet_dy != '1)
            fleet_dy <= fleet_dy + 11'd1;

         if (run)
            div_cnt <= tick ? '0 : div_cnt + DW'(1);

         if (line_crossed_any) begin
            game_over <= 1'b1;
            state     <= ST_HALT;
         end else if (!any_alive) begin
            fleet_cleared <= 1'b1;
            state         <= ST_HALT;
         end else if (tick) begin
            case (state)
               ST_MOVE_R:
                  if (right_edge >= RLIM) begin
                     shift_down <= 1'b1;
                     down_cnt   <= NW'(1);
                     state      <= ST_DOWN_R;
                  end else begin
                     shift_right <= 1'b1;
                  end
               ST_MOVE_L:
                  if (left_edge <= LLIM) begin
                     shift_down <= 1'b1;
                     down_cnt   <= NW'(1);
                     state      <= ST_DOWN_L;
                  end else begin
                     shift_left <= 1'b1;
                  end
               ST_DOWN_R, ST_DOWN_L: begin
                  shift_down <= 1'b1;
                  down_cnt   <= down_nxt;
                  if (down_nxt == NW'(DOWN_PX)) begin
                     state     <= (state == ST_DOWN_R) ? ST_MOVE_L : ST_MOVE_R;
                     dir_right <= ~dir_right;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_inv_fleet_ctrl.sv
// Scoreboard bench for inv_fleet_ctrl: a tick-level fleet model predicts each
// pulse and the offsets after it; a monitor matches what the DUT presents.
module tb_inv_fleet_ctrl;

   localparam int COLS = 4;
   localparam int PITCH = 80;
   localparam int SW = 60;
   localparam int X0 = 100;
   localparam int SDIV = 4;
   localparam int DPX = 15;
   localparam int LLIM = 10;
   localparam int RLIM = 790;

   logic clk = 1'b0;
   logic on_sw = 1'b0;
   logic en = 1'b0;
   logic line_crossed_any = 1'b0;
   logic [COLS-1:0] alive_cols = '1;
   logic shift_right, shift_left, shift_down, dir_right, game_over, fleet_cleared;
   logic signed [11:0] fleet_dx;
   logic [10:0] fleet_dy;

   inv_fleet_ctrl #(
      .COLS(COLS), .COL_PITCH(PITCH), .SHIP_W(SW), .FLEET_X0(X0),
      .LEFT_LIMIT(LLIM), .RIGHT_LIMIT(RLIM), .DOWN_PX(DPX), .STEP_DIV(SDIV)
   ) dut (
      .clk(clk), .on_sw(on_sw), .en(en), .alive_cols(alive_cols),
      .line_crossed_any(line_crossed_any),
      .shift_right(shift_right), .shift_left(shift_left), .shift_down(shift_down),
      .dir_right(dir_right), .fleet_dx(fleet_dx), .fleet_dy(fleet_dy),
      .game_over(game_over), .fleet_cleared(fleet_cleared)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   // kind: 0 right, 1 left, 2 down
   typedef struct { int kind; int cyc; int dx; int dy; bit dir; } exp_t;
   exp_t sb[$];

   int m_cnt, m_dx, m_dy, m_rem;
   bit m_dir, m_halt, m_go, m_fc;
   bit in_on, in_en, in_lc;
   logic [COLS-1:0] in_alive;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_dx = 0; m_dy = 0; m_rem = 0;
      m_dir = 1'b1; m_halt = 1'b0; m_go = 1'b0; m_fc = 1'b0;
   endtask

   // One clock of fleet behaviour, from the inputs applied in this cycle.
   task automatic model_cycle();
      int lo, hi, left, right;
      exp_t e;
      if (!in_on) begin
         model_reset();
         while (sb.size() > 0 && sb[$].cyc > cyc) void'(sb.pop_back());
         return;
      end
      if (in_lc) begin m_go = 1'b1; m_halt = 1'b1; return; end
      if (in_alive == '0) begin m_fc = 1'b1; m_halt = 1'b1; return; end
      if (m_halt || !in_en) return;
      m_cnt++;
      if (m_cnt < SDIV) return;
      m_cnt = 0;
      lo = -1; hi = -1;
      for (int i = 0; i < COLS; i++)
         if (in_alive[i]) begin
            if (lo < 0) lo = i;
            hi = i;
         end
      left  = X0 + m_dx + lo * PITCH;
      right = X0 + m_dx + hi * PITCH + SW;
      if (m_rem > 0) begin
         e.kind = 2; if (m_dy < 2047) m_dy++;
         m_rem--;
         if (m_rem == 0) m_dir = !m_dir;
      end else if ((m_dir && right >= RLIM) || (!m_dir && left <= LLIM)) begin
         e.kind = 2; if (m_dy < 2047) m_dy++;
         m_rem = DPX - 1;
         if (m_rem == 0) m_dir = !m_dir;
      end else if (m_dir) begin
         e.kind = 0; m_dx++;
      end else begin
         e.kind = 1; m_dx--;
      end
      e.cyc = cyc + 1; e.dx = m_dx; e.dy = m_dy; e.dir = m_dir;
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      on_sw = in_on; en = in_en; alive_cols = in_alive; line_crossed_any = in_lc;
      model_cycle();
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_shift_right"}, int'(shift_right), 0);
      chk({tag, "_shift_left"}, int'(shift_left), 0);
      chk({tag, "_shift_down"}, int'(shift_down), 0);
      chk({tag, "_dir_right"}, int'(dir_right), 1);
      chk({tag, "_fleet_dx"}, int'(fleet_dx), 0);
      chk({tag, "_fleet_dy"}, int'(fleet_dy), 0);
      chk({tag, "_game_over"}, int'(game_over), 0);
      chk({tag, "_fleet_cleared"}, int'(fleet_cleared), 0);
   endtask

   task automatic reset_dut(input string tag);
      in_en = 1'b0;
      repeat (3) step();
      in_on = 1'b0; step();
      in_on = 1'b1; in_en = 1'b1; step();
      check_reset(tag);
   endtask

   bit pend = 1'b0;
   exp_t pe;

   always @(negedge clk) begin : monitor
      int np, kind;
      exp_t e;
      if (pend) begin
         chk("dx_after_pulse", int'(fleet_dx), pe.dx);
         chk("dy_after_pulse", int'(fleet_dy), pe.dy);
         pend = 1'b0;
      end
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
         e = sb.pop_front();
         checks++; failures++;
         $display("FAIL missed_pulse: got none, expected kind %0d at cycle %0d", e.kind, e.cyc);
      end
      np = int'(shift_right) + int'(shift_left) + int'(shift_down);
      if (np > 0) begin
         chk("one_hot", np, 1);
         kind = shift_right ? 0 : (shift_left ? 1 : 2);
         if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, expected none", kind, cyc);
         end else begin
            e = sb.pop_front();
            chk("pulse_kind", kind, e.kind);
            chk("pulse_cycle", cyc, e.cyc);
            chk("dir_right", int'(dir_right), int'(e.dir));
            pe = e; pend = 1'b1;
         end
      end
   end

   initial begin
      in_on = 1'b0; in_en = 1'b1; in_lc = 1'b0; in_alive = '1;
      model_reset();
      step(); step();
      check_reset("por");
      in_on = 1'b1;

      // Full right sweep with a 10-cycle pause, then the first descent.
      repeat (150) step();
      in_en = 1'b0; repeat (10) step(); in_en = 1'b1;
      for (int n = 0; n < 4000 && !(m_dy == DPX && m_rem == 0); n++) step();
      chk("sweep1_reached", m_dy, DPX);
      repeat (3) step();
      chk("rev1_dx", int'(fleet_dx), 390);
      chk("rev1_dy", int'(fleet_dy), 15);
      chk("rev1_dir", int'(dir_right), 0);

      for (int n = 0; n < 4000 && !(m_dy == 2 * DPX && m_rem == 0); n++) step();
      chk("sweep2_reached", m_dy, 2 * DPX);
      repeat (3) step();
      chk("rev2_dx", int'(fleet_dx), -90);
      chk("rev2_dy", int'(fleet_dy), 30);
      chk("rev2_dir", int'(dir_right), 1);

      repeat (300) begin
         in_en = ($urandom_range(0, 3) != 0);
         step();
      end

      // Reset landing on a tick cycle cancels the pulse due next cycle.
      in_en = 1'b1;
      for (int n = 0; n < 10 && m_cnt != SDIV - 1; n++) step();
      in_on = 1'b0; step();
      in_on = 1'b1; step();
      check_reset("midtick");

      in_alive = 4'b0111;
      reset_dut("shrink3");
      for (int n = 0; n < 5000 && !(m_dy == DPX && m_rem == 0); n++) step();
      repeat (3) step();
      chk("shrink3_dx", int'(fleet_dx), 470);

      in_alive = 4'b0110;
      reset_dut("shrink2");
      for (int n = 0; n < 5000 && !(m_dy == DPX && m_rem == 0); n++) step();
      repeat (3) step();
      chk("shrink2_rdx", int'(fleet_dx), 470);
      for (int n = 0; n < 5000 && !(m_dy == 2 * DPX && m_rem == 0); n++) step();
      repeat (3) step();
      chk("shrink2_ldx", int'(fleet_dx), -170);

      // Random column loss and pauses.
      in_alive = '1;
      reset_dut("random");
      for (int n = 0; n < 800; n++) begin
         if (n % 40 == 39) in_alive = 4'($urandom_range(1, 15));
         in_en = ($urandom_range(0, 4) != 0);
         step();
      end

      // Both terminal conditions at once: only game_over.
      in_en = 1'b1;
      in_lc = 1'b1; in_alive = '0; step();
      in_lc = 1'b0; in_alive = '1;
      repeat (2) step();
      chk("term_game_over", int'(game_over), 1);
      chk("term_fleet_cleared", int'(fleet_cleared), 0);
      repeat (20) step();
      chk("term_sticky", int'(game_over), int'(m_go));

      reset_dut("post_term");
      repeat (30) step();
      in_alive = '0; step();
      in_alive = '1; repeat (2) step();
      chk("clear_fleet_cleared", int'(fleet_cleared), 1);
      chk("clear_game_over", int'(game_over), 0);
      repeat (10) step();

      in_en = 1'b0;
      repeat (3) step();
      chk("scoreboard_drain", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
